// File: rtl/lms_fir_pkg.sv
// Shared arithmetic helpers for the adaptive and fixed FIR datapaths.
// Latency: none (functions and constants only).
// Backpressure: not applicable.
package lms_fir_pkg;

    // Intermediate width wide enough for any product/accumulator before clamping
    localparam int SAT_W = 64;

    typedef logic signed [SAT_W-1:0] sat_t;

    // Full-precision width of one weight*sample product
    function automatic int prod_width(input int data_w, input int coeff_w);
        return data_w + coeff_w;
    endfunction

    // Accumulator width: product plus growth headroom for summing all taps
    function automatic int acc_width(input int data_w, input int coeff_w, input int taps);
        return data_w + coeff_w + $clog2(taps);
    endfunction

    // Clamp a signed value into the range of a signed field of 'width' bits
    function automatic sat_t sat_signed(input sat_t value, input int width);
        sat_t max_v;
        sat_t min_v;
        max_v = (sat_t'(1) <<< (width - 1)) - sat_t'(1);
        min_v = -(sat_t'(1) <<< (width - 1));
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/lms_weight.sv
// One LMS weight: external load, sign-exact err*x step update, saturating add.
// Latency: load or update visible one cycle after the qualifying edge.
// Backpressure: none; load takes priority and discards a coincident update.
module lms_weight
    import lms_fir_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int MU_SHIFT    = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_load,
    input  logic [COEFF_WIDTH-1:0] i_load_val,
    input  logic                   i_upd_en,
    input  logic [DATA_WIDTH-1:0]  i_err,
    input  logic [DATA_WIDTH-1:0]  i_x,
    output logic [COEFF_WIDTH-1:0] o_w
);

    // Rescales the Q2.(2D-2) product back to weight LSBs and applies mu in one shift
    localparam int UPD_SHIFT = 2 * DATA_WIDTH - COEFF_WIDTH - 1 + MU_SHIFT;

    logic [COEFF_WIDTH-1:0]         r_w;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [2*DATA_WIDTH-1:0] w_term;
    sat_t                           w_sum;
    logic [COEFF_WIDTH-1:0]         w_next;

    assign w_prod = $signed(i_err) * $signed(i_x);
    assign w_term = w_prod >>> UPD_SHIFT;
    assign w_sum  = sat_t'($signed(r_w)) + sat_t'(w_term);
    assign w_next = COEFF_WIDTH'(sat_signed(w_sum, COEFF_WIDTH));
    assign o_w    = r_w;

    // Weight register: load wins over the adaptive step
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_w <= '0;
        end else if (i_load) begin
            r_w <= i_load_val;
        end else if (i_upd_en) begin
            r_w <= w_next;
        end
    end

endmodule

// File: rtl/lms_adaptive_fir.sv
// Direct-form FIR with delayed sign-exact LMS weight adaptation and external weight load.
// Latency: 2 cycles din_valid -> dout_valid; weight update lands 1 cycle after dout_valid.
// Backpressure: none; accepts one sample every cycle, idle cycles hold all state.
module lms_adaptive_fir
    import lms_fir_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int TAPS        = 8,
    parameter int MU_SHIFT    = 4
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              din_valid,
    input  logic [DATA_WIDTH-1:0]             din,
    input  logic [DATA_WIDTH-1:0]             desired,
    input  logic                              adapt_en,
    input  logic                              coeff_load,
    input  logic [TAPS-1:0][COEFF_WIDTH-1:0]  coeff_in,
    output logic                              dout_valid,
    output logic [DATA_WIDTH-1:0]             dout,
    output logic [DATA_WIDTH-1:0]             err,
    output logic [TAPS-1:0][COEFF_WIDTH-1:0]  coeffs_out
);

    localparam int PROD_W = prod_width(DATA_WIDTH, COEFF_WIDTH);
    localparam int ACC_W  = acc_width(DATA_WIDTH, COEFF_WIDTH, TAPS);

    logic [TAPS-1:0][DATA_WIDTH-1:0]   r_x_line;
    logic [TAPS-1:0][DATA_WIDTH-1:0]   r_x_snap;
    logic [DATA_WIDTH-1:0]             r_d_q;
    logic                              r_v1;
    logic [DATA_WIDTH-1:0]             r_dout;
    logic [DATA_WIDTH-1:0]             r_err;
    logic                              r_dout_valid;

    logic [TAPS-1:0][COEFF_WIDTH-1:0]  w_w;
    logic signed [PROD_W-1:0]          w_prod [TAPS];
    logic signed [ACC_W-1:0]           w_acc;
    logic [DATA_WIDTH-1:0]             w_y;
    logic signed [DATA_WIDTH:0]        w_e_wide;
    logic [DATA_WIDTH-1:0]             w_err;
    logic                              w_upd_en;

    // Update uses the err/x pair of the output just produced; it is one sample late
    // relative to the MAC when samples arrive back to back.
    assign w_upd_en = r_dout_valid & adapt_en;

    genvar g_tap;
    generate
        for (g_tap = 0; g_tap < TAPS; g_tap++) begin : g_taps
            lms_weight #(
                .DATA_WIDTH  (DATA_WIDTH),
                .COEFF_WIDTH (COEFF_WIDTH),
                .MU_SHIFT    (MU_SHIFT)
            ) u_weight (
                .clk        (clk),
                .rstn       (rstn),
                .i_load     (coeff_load),
                .i_load_val (coeff_in[g_tap]),
                .i_upd_en   (w_upd_en),
                .i_err      (r_err),
                .i_x        (r_x_snap[g_tap]),
                .o_w        (w_w[g_tap])
            );
            assign w_prod[g_tap] = $signed(w_w[g_tap]) * $signed(r_x_line[g_tap]);
        end
    endgenerate

    // Full-precision sum of all tap products
    always_comb begin
        w_acc = '0;
        for (int i = 0; i < TAPS; i++) begin
            w_acc = w_acc + ACC_W'(w_prod[i]);
        end
    end

    // Floor back to Q1 data format, clamp; error computed one bit wider then clamped
    assign w_y      = DATA_WIDTH'(sat_signed(sat_t'(w_acc >>> (COEFF_WIDTH - 1)), DATA_WIDTH));
    assign w_e_wide = $signed({r_d_q[DATA_WIDTH-1], r_d_q}) - $signed({w_y[DATA_WIDTH-1], w_y});
    assign w_err    = DATA_WIDTH'(sat_signed(sat_t'(w_e_wide), DATA_WIDTH));

    // Input stage: shift the delay line and capture the reference only on valid samples
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_x_line <= '0;
            r_d_q    <= '0;
            r_v1     <= 1'b0;
        end else begin
            r_v1 <= din_valid;
            if (din_valid) begin
                r_x_line <= {r_x_line[TAPS-2:0], din};
                r_d_q    <= desired;
            end
        end
    end

    // Output stage: register y/err and freeze the history that produced them for the update
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dout       <= '0;
            r_err        <= '0;
            r_x_snap     <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= r_v1;
            if (r_v1) begin
                r_dout   <= w_y;
                r_err    <= w_err;
                r_x_snap <= r_x_line;
            end
        end
    end

    assign dout_valid = r_dout_valid;
    assign dout       = r_dout;
    assign err        = r_err;
    assign coeffs_out = w_w;

endmodule

// File: tb/tb_lms_adaptive_fir.sv
// Directed self-checking bench for lms_adaptive_fir (DATA=COEFF=16, TAPS=8, MU_SHIFT=4).
module tb_lms_adaptive_fir;

    localparam int DW   = 16;
    localparam int CW   = 16;
    localparam int TAPS = 8;

    logic                       clk;
    logic                       rstn;
    logic                       din_valid;
    logic [DW-1:0]              din;
    logic [DW-1:0]              desired;
    logic                       adapt_en;
    logic                       coeff_load;
    logic [TAPS-1:0][CW-1:0]    coeff_in;
    logic                       dout_valid;
    logic [DW-1:0]              dout;
    logic [DW-1:0]              err;
    logic [TAPS-1:0][CW-1:0]    coeffs_out;

    int errors = 0;
    int checks = 0;
    int vcount = 0;

    lms_adaptive_fir #(
        .DATA_WIDTH  (DW),
        .COEFF_WIDTH (CW),
        .TAPS        (TAPS),
        .MU_SHIFT    (4)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .din_valid  (din_valid),
        .din        (din),
        .desired    (desired),
        .adapt_en   (adapt_en),
        .coeff_load (coeff_load),
        .coeff_in   (coeff_in),
        .dout_valid (dout_valid),
        .dout       (dout),
        .err        (err),
        .coeffs_out (coeffs_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dout_valid) vcount <= vcount + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] x, input logic [DW-1:0] d);
        din_valid = 1'b1;
        din       = x;
        desired   = d;
        step();
    endtask

    // Idle cycles drive junk on din/desired to show they are ignored
    task automatic idle(input int n);
        din_valid = 1'b0;
        din       = 16'h7FFF;
        desired   = 16'h1234;
        repeat (n) step();
    endtask

    task automatic load_w(input logic [TAPS-1:0][CW-1:0] vals);
        coeff_in   = vals;
        coeff_load = 1'b1;
        step();
        coeff_load = 1'b0;
    endtask

    task automatic do_reset();
        din_valid  = 1'b0;
        coeff_load = 1'b0;
        adapt_en   = 1'b0;
        rstn       = 1'b0;
        step();
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic test_reset();
        logic [TAPS-1:0][CW-1:0] cv;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #1;
        checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL reset_init_dout: got %h want 0000", dout); end
        checks++; if (err !== 16'h0000) begin errors++; $display("FAIL reset_init_err: got %h want 0000", err); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_init_vld: got %b want 0", dout_valid); end
        step();
        rstn = 1'b1;
        step();
        cv = '0;
        cv[0] = 16'h4000;
        load_w(cv);
        push(16'h7FFF, 16'h0000);
        push(16'h7FFF, 16'h0000);
        push(16'h7FFF, 16'h0000);
        checks++; if (dout_valid !== 1'b1 || dout !== 16'h3FFF) begin errors++; $display("FAIL reset_prestream: got vld=%b dout=%h want 1 3FFF", dout_valid, dout); end
        // Assert reset asynchronously while valids keep streaming
        #2 rstn = 1'b0;
        #1;
        checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL reset_mid_dout: got %h want 0000", dout); end
        checks++; if (err !== 16'h0000) begin errors++; $display("FAIL reset_mid_err: got %h want 0000", err); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_vld: got %b want 0", dout_valid); end
        for (int i = 0; i < TAPS; i++) begin
            checks++; if (coeffs_out[i] !== 16'h0000) begin errors++; $display("FAIL reset_mid_w%0d: got %h want 0000", i, coeffs_out[i]); end
        end
        step();
        step();
        din_valid = 1'b0;
        rstn = 1'b1;
        step();
        // Only tap 0 should see data: history must be empty after reset
        cv = {TAPS{16'h4000}};
        load_w(cv);
        push(16'h2000, 16'h0000);
        idle(1);
        checks++; if (dout_valid !== 1'b1 || dout !== 16'h1000) begin errors++; $display("FAIL reset_first_dout: got vld=%b dout=%h want 1 1000", dout_valid, dout); end
        checks++; if (err !== 16'hF000) begin errors++; $display("FAIL reset_first_err: got %h want F000", err); end
    endtask

    task automatic test_fixed_fir();
        logic [TAPS-1:0][CW-1:0] cv;
        do_reset();
        cv = '0;
        cv[0] = 16'h4000;
        load_w(cv);
        push(16'h7FFF, 16'h0000);
        din_valid = 1'b0;
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL fir_early_vld: got %b want 0", dout_valid); end
        idle(1);
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL fir_vld: got %b want 1", dout_valid); end
        checks++; if (dout !== 16'h3FFF) begin errors++; $display("FAIL fir_impulse_dout: got %h want 3FFF", dout); end
        checks++; if (err !== 16'hC001) begin errors++; $display("FAIL fir_impulse_err: got %h want C001", err); end
        idle(1);
        checks++; if (dout_valid !== 1'b0 || dout !== 16'h3FFF) begin errors++; $display("FAIL fir_hold: got vld=%b dout=%h want 0 3FFF", dout_valid, dout); end
        push(16'h0000, 16'h0000);
        idle(1);
        checks++; if (dout !== 16'h0000 || err !== 16'h0000) begin errors++; $display("FAIL fir_tail: got dout=%h err=%h want 0000 0000", dout, err); end
    endtask

    task automatic test_saturation();
        do_reset();
        load_w({TAPS{16'h7FFF}});
        for (int i = 0; i < 7; i++) push(16'h7FFF, 16'h0000);
        push(16'h7FFF, 16'h8000);
        push(16'h8000, 16'h0000);
        checks++; if (dout !== 16'h7FFF) begin errors++; $display("FAIL sat_pos_dout: got %h want 7FFF", dout); end
        checks++; if (err !== 16'h8000) begin errors++; $display("FAIL sat_neg_err: got %h want 8000", err); end
        for (int i = 0; i < 7; i++) push(16'h8000, 16'h0000);
        idle(1);
        checks++; if (dout !== 16'h8000) begin errors++; $display("FAIL sat_neg_dout: got %h want 8000", dout); end
        checks++; if (err !== 16'h7FFF) begin errors++; $display("FAIL sat_pos_err: got %h want 7FFF", err); end
    endtask

    task automatic test_lms_step();
        logic signed [DW-1:0] se;
        do_reset();
        adapt_en = 1'b1;
        push(16'h4000, 16'h4000);
        idle(1);
        checks++; if (dout_valid !== 1'b1 || dout !== 16'h0000) begin errors++; $display("FAIL lms_first_dout: got vld=%b dout=%h want 1 0000", dout_valid, dout); end
        checks++; if (err !== 16'h4000) begin errors++; $display("FAIL lms_first_err: got %h want 4000", err); end
        idle(1);
        checks++; if (coeffs_out[0] !== 16'h0200) begin errors++; $display("FAIL lms_w0: got %h want 0200", coeffs_out[0]); end
        for (int i = 1; i < TAPS; i++) begin
            checks++; if (coeffs_out[i] !== 16'h0000) begin errors++; $display("FAIL lms_w%0d: got %h want 0000", i, coeffs_out[i]); end
        end
        for (int i = 0; i < 300; i++) push(16'h7FFF, 16'h7FFF);
        idle(1);
        se = err;
        checks++; if (se > 16 || se < -16) begin errors++; $display("FAIL lms_converge: got err=%h want |err|<=0010", err); end
        adapt_en = 1'b0;
    endtask

    task automatic test_collision();
        do_reset();
        adapt_en = 1'b1;
        push(16'h4000, 16'h4000);
        idle(1);
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL coll_vld: got %b want 1", dout_valid); end
        // Load lands on the same edge as the pending update
        load_w({TAPS{16'h1000}});
        for (int i = 0; i < TAPS; i++) begin
            checks++; if (coeffs_out[i] !== 16'h1000) begin errors++; $display("FAIL coll_w%0d: got %h want 1000", i, coeffs_out[i]); end
        end
        adapt_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i < 12) push(i[0] ? 16'h8000 : 16'h7FFF, 16'h2000);
            else push(16'h4000, 16'h0000);
        end
        idle(2);
        checks++; if (dout !== 16'h4000 || err !== 16'hC000) begin errors++; $display("FAIL hold_out: got dout=%h err=%h want 4000 C000", dout, err); end
        for (int i = 0; i < TAPS; i++) begin
            checks++; if (coeffs_out[i] !== 16'h1000) begin errors++; $display("FAIL hold_w%0d: got %h want 1000", i, coeffs_out[i]); end
        end
    endtask

    task automatic test_gaps();
        logic [TAPS-1:0][CW-1:0] cv;
        logic [DW-1:0] xs [3];
        logic [DW-1:0] ys [3];
        logic [DW-1:0] es [3];
        int v0;
        xs = '{16'h4000, 16'h1000, 16'hC000};
        ys = '{16'h2000, 16'h1800, 16'hE400};
        es = '{16'hE000, 16'hE800, 16'h1C00};
        cv = '0;
        cv[0] = 16'h4000;
        cv[1] = 16'h2000;
        do_reset();
        load_w(cv);
        v0 = vcount;
        for (int k = 0; k < 3; k++) begin
            push(xs[k], 16'h0000);
            idle(1);
            checks++; if (dout_valid !== 1'b1 || dout !== ys[k] || err !== es[k]) begin errors++; $display("FAIL gap_out%0d: got vld=%b dout=%h err=%h want 1 %h %h", k, dout_valid, dout, err, ys[k], es[k]); end
            idle(1);
            checks++; if (dout_valid !== 1'b0 || dout !== ys[k]) begin errors++; $display("FAIL gap_hold%0d: got vld=%b dout=%h want 0 %h", k, dout_valid, dout, ys[k]); end
        end
        idle(1);
        checks++; if (vcount - v0 !== 3) begin errors++; $display("FAIL gap_pulses: got %0d want 3", vcount - v0); end
        do_reset();
        load_w(cv);
        v0 = vcount;
        push(xs[0], 16'h0000);
        push(xs[1], 16'h0000);
        checks++; if (dout !== ys[0]) begin errors++; $display("FAIL b2b_out0: got %h want %h", dout, ys[0]); end
        push(xs[2], 16'h0000);
        checks++; if (dout !== ys[1] || err !== es[1]) begin errors++; $display("FAIL b2b_out1: got dout=%h err=%h want %h %h", dout, err, ys[1], es[1]); end
        idle(1);
        checks++; if (dout !== ys[2] || err !== es[2]) begin errors++; $display("FAIL b2b_out2: got dout=%h err=%h want %h %h", dout, err, ys[2], es[2]); end
        idle(2);
        checks++; if (vcount - v0 !== 3) begin errors++; $display("FAIL b2b_pulses: got %0d want 3", vcount - v0); end
    endtask

    initial begin
        din_valid  = 1'b0;
        din        = '0;
        desired    = '0;
        adapt_en   = 1'b0;
        coeff_load = 1'b0;
        coeff_in   = '0;
        test_reset();
        test_fixed_fir();
        test_saturation();
        test_lms_step();
        test_collision();
        test_gaps();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
